// File: rtl/wburst_counter_mc.sv
// wburst_counter_mc
// Multi-channel write-burst scheduler. Each channel counts beats accepted
// into its write buffer; a channel becomes eligible once it holds a full
// burst or has a pending flush with residual beats. Eligible channels are
// granted round-robin and one burst request at a time is presented to the
// AW issue logic.
//
// Handshake: wburst_ready is held high with wburst_ch/wburst_len stable
// until wburst_issued is sampled high in the same cycle; that cycle is the
// transfer. wburst_issued while wburst_ready is low has no effect.
// The FSM state is the signal `state` (IDLE/READY), with `last_grant`
// holding the round-robin pointer.
module wburst_counter_mc #(
  parameter int NUM_CH             = 4,
  parameter int CH_BITS            = 2,
  parameter int WBURST_COUNTER_LEN = 16,
  parameter int WBURST_LEN         = 4,
  parameter int MAX_BURST_LEN      = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_CH-1:0]     write_valid,
  input  logic [NUM_CH-1:0]     write_flush,
  output logic                  wburst_ready,
  output logic [CH_BITS-1:0]    wburst_ch,
  output logic [WBURST_LEN-1:0] wburst_len,
  input  logic                  wburst_issued,
  output logic [NUM_CH-1:0]     count_overflow
);

  localparam int CW = WBURST_COUNTER_LEN;

  typedef enum logic {
    IDLE  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                state;
  logic [CH_BITS-1:0]    last_grant;

  logic [CW-1:0]         cnt      [NUM_CH];
  logic [CW-1:0]         cnt_next [NUM_CH];
  logic [CW-1:0]         ded      [NUM_CH];
  logic [NUM_CH-1:0]     hit;
  logic [NUM_CH-1:0]     flush_pend;
  logic [NUM_CH-1:0]     flush_pend_next;
  logic [NUM_CH-1:0]     ovf_set;
  logic [NUM_CH-1:0]     eligible;

  logic                  gnt_found;
  logic [CH_BITS-1:0]    gnt_ch;
  logic [CH_BITS-1:0]    idx;
  logic [CW-1:0]         gnt_cnt;
  logic [WBURST_LEN-1:0] gnt_len;

  // Per-channel next count, deduction on issue, saturation and flush tracking
  always_comb begin
    hit             = '0;
    ovf_set         = '0;
    flush_pend_next = '0;
    eligible        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ded[i]      = '0;
      cnt_next[i] = cnt[i];
    end
    for (int i = 0; i < NUM_CH; i++) begin
      hit[i] = wburst_ready && wburst_issued && (wburst_ch == CH_BITS'(i));
      ded[i] = hit[i] ? (CW'(wburst_len) + CW'(1)) : '0;
      // A full counter with an incoming beat and nothing leaving would wrap;
      // hold it instead and flag the loss.
      ovf_set[i] = (&cnt[i]) && write_valid[i] && !hit[i];
      cnt_next[i] = ovf_set[i] ? cnt[i] : (cnt[i] + CW'(write_valid[i]) - ded[i]);
      // A flush only survives while the channel still has beats to send.
      flush_pend_next[i] = (flush_pend[i] | write_flush[i]) && (cnt_next[i] != '0);
      eligible[i] = (cnt[i] >= CW'(MAX_BURST_LEN)) || (flush_pend[i] && (cnt[i] != '0));
    end
  end

  // Round-robin search starting one past the last granted channel
  always_comb begin
    gnt_found = 1'b0;
    gnt_ch    = '0;
    gnt_cnt   = '0;
    idx       = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = CH_BITS'((int'(last_grant) + k) % NUM_CH);
      if (!gnt_found && eligible[idx]) begin
        gnt_found = 1'b1;
        gnt_ch    = idx;
        gnt_cnt   = cnt[idx];
      end
    end
    gnt_len = (gnt_cnt >= CW'(MAX_BURST_LEN)) ? WBURST_LEN'(MAX_BURST_LEN - 1)
                                             : WBURST_LEN'(gnt_cnt - CW'(1));
  end

  // Counter, flush-pending and sticky overflow registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      flush_pend     <= '0;
      count_overflow <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= cnt_next[i];
      flush_pend     <= flush_pend_next;
      count_overflow <= count_overflow | ovf_set;
    end
  end

  // Grant FSM: latch channel/length in IDLE, hold request until issued
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      wburst_ready <= 1'b0;
      wburst_ch    <= '0;
      wburst_len   <= '0;
      last_grant   <= CH_BITS'(NUM_CH - 1);
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            wburst_ch    <= gnt_ch;
            wburst_len   <= gnt_len;
            wburst_ready <= 1'b1;
            state        <= READY;
          end
        end
        READY: begin
          if (wburst_issued) begin
            wburst_ready <= 1'b0;
            last_grant   <= wburst_ch;
            state        <= IDLE;
          end
        end
        default: begin
          wburst_ready <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wburst_counter_mc.sv
// Testbench for wburst_counter_mc: directed steps in one initial block,
// a burst scoreboard fed by the stimulus and drained by a handshake monitor.
module tb_wburst_counter_mc;

  logic       clk;
  logic       resetn;
  logic [3:0] write_valid;
  logic [3:0] write_flush;
  logic       wburst_issued;
  logic       wburst_ready;
  logic [1:0] wburst_ch;
  logic [3:0] wburst_len;
  logic [3:0] count_overflow;

  // Narrow-counter instance for saturation checks
  logic [3:0] ov_wv;
  logic [3:0] ov_wf;
  logic       ov_iss;
  logic       ov_ready;
  logic [1:0] ov_ch;
  logic [3:0] ov_len;
  logic [3:0] ov_ovf;

  int n_assert = 0;
  int n_fail   = 0;

  // Expected bursts as {ch, len}
  logic [5:0] exp_q[$];
  logic [5:0] exp_v;

  wburst_counter_mc dut (
    .clk            (clk),
    .resetn         (resetn),
    .write_valid    (write_valid),
    .write_flush    (write_flush),
    .wburst_ready   (wburst_ready),
    .wburst_ch      (wburst_ch),
    .wburst_len     (wburst_len),
    .wburst_issued  (wburst_issued),
    .count_overflow (count_overflow)
  );

  wburst_counter_mc #(.WBURST_COUNTER_LEN(5)) dut_ov (
    .clk            (clk),
    .resetn         (resetn),
    .write_valid    (ov_wv),
    .write_flush    (ov_wf),
    .wburst_ready   (ov_ready),
    .wburst_ch      (ov_ch),
    .wburst_len     (ov_len),
    .wburst_issued  (ov_iss),
    .count_overflow (ov_ovf)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Move to the next cycle; outputs are then settled after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_beats(input int ch, input int n);
    for (int b = 0; b < n; b++) begin
      write_valid = 4'(1 << ch);
      tick();
    end
    write_valid = 4'b0;
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int c = 0; c < n; c++) begin
      chk(tag, {31'b0, wburst_ready}, 32'd0);
      tick();
    end
  endtask

  // Wait (bounded) for a request, hold it for delay cycles, then issue it
  task automatic wait_burst(input int delay, input logic [3:0] wv);
    for (int t = 0; t < 100 && !wburst_ready; t++) tick();
    chk("wait_ready", {31'b0, wburst_ready}, 32'd1);
    for (int d = 0; d < delay; d++) begin
      tick();
      chk("ready_held", {31'b0, wburst_ready}, 32'd1);
    end
    wburst_issued = 1'b1;
    write_valid   = wv;
    tick();
    wburst_issued = 1'b0;
    write_valid   = 4'b0;
    chk("ready_drop_after_issue", {31'b0, wburst_ready}, 32'd0);
  endtask

  // Scoreboard: every accepted burst must match the next expected one
  always @(negedge clk) begin
    if (resetn && wburst_ready && wburst_issued) begin
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected observed=%0h expected=none", {wburst_ch, wburst_len});
      end
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        chk("sb_burst", {26'b0, wburst_ch, wburst_len}, {26'b0, exp_v});
      end
    end
  end

  initial begin
    resetn        = 1'b0;
    write_valid   = '0;
    write_flush   = '0;
    wburst_issued = 1'b0;
    ov_wv = '0; ov_wf = '0; ov_iss = 1'b0;

    // Reset held with random inputs: everything stays cleared
    for (int c = 0; c < 6; c++) begin
      write_valid   = 4'($urandom_range(0, 15));
      write_flush   = 4'($urandom_range(0, 15));
      wburst_issued = 1'($urandom_range(0, 1));
      ov_wv         = 4'($urandom_range(0, 15));
      tick();
      chk("rst_ready", {31'b0, wburst_ready}, 32'd0);
      chk("rst_ch",    {30'b0, wburst_ch},    32'd0);
      chk("rst_len",   {28'b0, wburst_len},   32'd0);
      chk("rst_ovf",   {28'b0, count_overflow}, 32'd0);
    end
    write_valid = '0; write_flush = '0; wburst_issued = 1'b0; ov_wv = '0;
    resetn = 1'b1;
    tick();

    // Full burst on ch2 with issue tied high
    wburst_issued = 1'b1;
    exp_q.push_back({2'd2, 4'd15});
    write_beats(2, 16);
    chk("full_latency_n1", {31'b0, wburst_ready}, 32'd0);
    tick();
    chk("full_latency_n2", {31'b0, wburst_ready}, 32'd1);
    chk("full_ch",  {30'b0, wburst_ch},  32'd2);
    chk("full_len", {28'b0, wburst_len}, 32'd15);
    tick();
    wburst_issued = 1'b0;
    idle_check("full_cnt_cleared", 6);

    // Partial burst by flush on ch1, then flush of empty ch3
    write_beats(1, 5);
    write_flush = 4'b0010;
    tick();
    write_flush = 4'b0000;
    exp_q.push_back({2'd1, 4'd4});
    wait_burst(0, 4'b0000);
    idle_check("flush_no_repeat", 6);
    write_flush = 4'b1000;
    tick();
    write_flush = 4'b0000;
    idle_check("flush_empty_dropped", 6);
    chk("sb_drained_a", exp_q.size(), 32'd0);

    // Round-robin from reset pointer, refill ch0 while ch1 waits
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    exp_q.push_back({2'd0, 4'd15});
    exp_q.push_back({2'd1, 4'd15});
    exp_q.push_back({2'd3, 4'd15});
    exp_q.push_back({2'd0, 4'd15});
    write_valid = 4'b1011;
    repeat (16) tick();
    write_valid = 4'b0000;
    wait_burst(3, 4'b0000);
    write_beats(0, 16);
    wait_burst(3, 4'b0000);
    wait_burst(3, 4'b0000);
    wait_burst(3, 4'b0000);
    idle_check("rr_done", 5);
    chk("sb_drained_b", exp_q.size(), 32'd0);

    // Write in the issue cycle on the granted channel, flush pending
    write_beats(0, 20);
    write_flush = 4'b0001;
    tick();
    write_flush = 4'b0000;
    exp_q.push_back({2'd0, 4'd15});
    exp_q.push_back({2'd0, 4'd4});
    wait_burst(0, 4'b0001);
    wait_burst(0, 4'b0000);
    idle_check("concurrent_idle", 6);
    chk("sb_drained_c", exp_q.size(), 32'd0);

    // Saturation on the 5-bit counter instance
    for (int b = 0; b < 31; b++) begin
      ov_wv = 4'b0001;
      tick();
    end
    ov_wv = 4'b0000;
    chk("ov_not_yet", {28'b0, ov_ovf}, 32'd0);
    chk("ov_ready_full", {31'b0, ov_ready}, 32'd1);
    chk("ov_len_full", {28'b0, ov_len}, 32'd15);
    ov_wv = 4'b0001;
    tick();
    ov_wv = 4'b0000;
    chk("ov_set", {28'b0, ov_ovf}, 32'd1);
    ov_iss = 1'b1;
    tick();
    ov_iss = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("ov_rem15_idle", {31'b0, ov_ready}, 32'd0);
      tick();
    end
    ov_wf = 4'b0001;
    tick();
    ov_wf = 4'b0000;
    for (int t = 0; t < 10 && !ov_ready; t++) tick();
    chk("ov_flush_ready", {31'b0, ov_ready}, 32'd1);
    chk("ov_flush_ch", {30'b0, ov_ch}, 32'd0);
    chk("ov_flush_len", {28'b0, ov_len}, 32'd14);
    ov_iss = 1'b1;
    tick();
    ov_iss = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("ov_empty_idle", {31'b0, ov_ready}, 32'd0);
      chk("ov_sticky", {28'b0, ov_ovf}, 32'd1);
      tick();
    end
    resetn = 1'b0;
    #1;
    chk("ov_cleared_by_reset", {28'b0, ov_ovf}, 32'd0);
    tick();
    resetn = 1'b1;
    tick();

    // Asynchronous reset while a request is presented
    write_beats(2, 16);
    for (int t = 0; t < 10 && !wburst_ready; t++) tick();
    chk("pre_async_ready", {31'b0, wburst_ready}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("async_ready_drop", {31'b0, wburst_ready}, 32'd0);
    chk("async_ch", {30'b0, wburst_ch}, 32'd0);
    chk("async_len", {28'b0, wburst_len}, 32'd0);
    tick();
    resetn = 1'b1;
    idle_check("after_async_reset", 6);
    chk("sb_drained_final", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wburst_counter_mc.md
# wburst_counter_mc

Multi-channel write-burst scheduler for the AXI master write path. Counts data beats written into each of `NUM_CH` per-channel write buffers, forms full bursts of `MAX_BURST_LEN` beats or partial bursts on flush, and presents one burst request at a time to the AW-channel issue logic. Channels are served round-robin. It replaces the single-channel write-burst counter when several PE write streams share one AXI master.

## Interface
- `NUM_CH`, 4: number of write channels (≥2)
- `CH_BITS`, 2: width of channel index, ≥ clog2(`NUM_CH`)
- `WBURST_COUNTER_LEN`, 16: per-channel beat counter width
- `WBURST_LEN`, 4: AXI burst length field width (beats−1 encoding)
- `MAX_BURST_LEN`, 16: beats in a full burst, ≤ 2^`WBURST_LEN`
- `clk` in 1: clock; single clock domain
- `resetn` in 1: reset, asynchronous, active-low
- `write_valid` in `NUM_CH`: bit i = one beat accepted into channel i buffer this cycle
- `write_flush` in `NUM_CH`: bit i = single-cycle pulse requesting that channel i's residual beats be issued as a partial burst
- `wburst_ready` out 1: burst request valid
- `wburst_ch` out `CH_BITS`: channel of presented burst
- `wburst_len` out `WBURST_LEN`: presented burst length, beats−1
- `wburst_issued` in 1: AW issue logic accepts the presented burst this cycle
- `count_overflow` out `NUM_CH`: sticky per-channel counter-overflow error

## Operation
- Per channel i: counter `cnt[i]` and flag `flush_pend[i]`.
- Deduction `ded[i]` = `wburst_len`+1 when `wburst_ready && wburst_issued && wburst_ch==i`, else 0.
- `cnt_next[i]` = `cnt[i]` + `write_valid[i]` − `ded[i]`, computed at `WBURST_COUNTER_LEN` bits.
- Overflow: if `cnt[i]` is all-ones, `write_valid[i]`=1 and `ded[i]`=0, `cnt[i]` holds and `count_overflow[i]` sets. It clears only on reset.
- `flush_pend_next[i]` = (`flush_pend[i]` | `write_flush[i]`) && `cnt_next[i]`≠0.
  - Flush of an empty channel with no same-cycle write is dropped.
  - A flush stays pending while writes keep arriving.
- Eligible[i] = `cnt[i]` ≥ `MAX_BURST_LEN`, or (`flush_pend[i]` && `cnt[i]`>0). Both use registered values.
- FSM, two states:
  - IDLE: if any channel is eligible, grant the first eligible channel searching from `last_grant`+1 modulo `NUM_CH`.
    - Register `wburst_ch` = granted channel.
    - Register `wburst_len` = min(`cnt`, `MAX_BURST_LEN`) − 1.
    - Go to READY.
  - READY: `wburst_ready`=1. On `wburst_issued`: apply the deduction, set `last_grant`=`wburst_ch`, go to IDLE. Otherwise hold; `wburst_ch`/`wburst_len` are stable.
- No underflow is possible: a latched length is ≤ `cnt`, and only the granted channel is ever deducted.
- `wburst_issued` in IDLE is ignored.
- Writes to any channel, including the granted one, continue counting while READY. The latched length is not updated.
- Reset values:
  - `wburst_ready`=0, `wburst_ch`=0, `wburst_len`=0, `count_overflow`=0
  - all `cnt`=0, all `flush_pend`=0, state IDLE
  - `last_grant`=`NUM_CH`−1, so channel 0 wins first.

## Timing
- Counters and flags update on the rising `clk` edge after the cycle of `write_valid`/`write_flush`.
- Eligibility visible in cycle N → `wburst_ready` high in N+1.
  - Example: 16th beat written in cycle N → `cnt`=16 in N+1 → `wburst_ready` in N+2.
- Issue handshake in cycle M → `wburst_ready` low in M+1. A next burst can be ready in M+2 at the earliest, so there is at least one idle cycle between bursts.
- The deduction and a same-cycle `write_valid` on the same channel both apply in one edge.
- `resetn` low at any time, including mid-READY: all state clears asynchronously and `wburst_ready` drops without waiting for a clock edge. Deassertion is assumed synchronised externally.

## Test plan
- Reset: hold `resetn`=0 with random inputs → all outputs 0. Assert `resetn`=0 during READY → `wburst_ready` falls before the next edge.
- Full burst: 16 beats on ch2, one per cycle, `wburst_issued` tied 1 → `wburst_ready` two cycles after the last beat, `wburst_ch`=2, `wburst_len`=15. `cnt[2]`=0 afterwards.
- Flush partial: 5 beats on ch1, then `write_flush[1]` → burst with `wburst_len`=4; after issue, `flush_pend[1]`=0 and no further request. A flush on an empty ch3 → no request.
- Round-robin: ch0, ch1 and ch3 each hold 16 beats, `wburst_issued` delayed 3 cycles per grant → grant order 0, 1, 3, then 0 again after ch0 is refilled.
- Concurrent write/deduct: ch0 with 20 beats and flush pending, with a beat written in the issue cycle → first `wburst_len`=15, `cnt[0]`=5, second `wburst_len`=4, then idle.
- Overflow: with `WBURST_COUNTER_LEN`=5 and `MAX_BURST_LEN`=16, `wburst_issued` held 0, write 32 beats to ch0 → `cnt[0]` saturates at 31, `count_overflow[0]`=1 and stays 1 until reset.
